ad9231_cfg_seq: RTL and testbench
=================================

AD9231_CFG_SEQ -- requirements
Module: ad9231_cfg_seq

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 8: register-table depth, legal range 1..64.
REQ-002 SHALL have parameter PWRUP_CYC, default 2000: clk_200m cycles waited before the first transaction.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096: cycles allowed per transaction for spi_over.
REQ-004 SHALL have parameter MAX_RETRY, default 3: retries per entry before error.
REQ-005 SHALL have port clk_200m, input, 1: clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that reruns the sequence from entry 0.
REQ-008 SHALL have port tbl_idx, output, 6: current table index.
REQ-009 SHALL have port tbl_addr, input, 13: register address for tbl_idx, combinational, valid in the same cycle.
REQ-010 SHALL have port tbl_data, input, 8: write data and expected readback value.
REQ-011 SHALL have port tbl_chk, input, 1: 1 = verify the write by readback.
REQ-012 SHALL have port spi_addr, output, 13: transaction address.
REQ-013 SHALL have port spi_data, output, 8: transaction write data.
REQ-014 SHALL have port spi_read, output, 1: 0 = write, 1 = read.
REQ-015 SHALL have port spi_flag, output, 1: one-cycle request pulse to the SPI master.
REQ-016 SHALL have port spi_over, input, 1: one-cycle completion pulse from the SPI master.
REQ-017 SHALL have port spi_rdata, input, 8: readback byte, valid when spi_over is high after a read.
REQ-018 SHALL have port powerdown, output, 1: AD9231 PDWN; 1 = held in power-down.
REQ-019 SHALL have ports busy, done and err, outputs, 1 each: status flags.
REQ-020 SHALL have port err_idx, output, 6: index of the failing entry.

Function
REQ-021 SHALL implement states IDLE, PWR_WAIT, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, NEXT, DONE and ERROR.
REQ-022 SHALL leave reset in PWR_WAIT with the delay counter at 0, powerdown=0 and busy=1.
REQ-023 In PWR_WAIT, SHALL count PWRUP_CYC cycles, then clear tbl_idx and the retry count and enter ISSUE_WR.
REQ-024 In ISSUE_WR, SHALL register spi_addr=tbl_addr, spi_data=tbl_data and spi_read=0, and pulse spi_flag for exactly one cycle.
REQ-025 SHALL hold spi_addr, spi_data and spi_read stable from the spi_flag pulse until spi_over.
REQ-026 In WAIT_WR, on spi_over SHALL go to ISSUE_RD if tbl_chk=1, otherwise to NEXT.
REQ-027 In ISSUE_RD, SHALL keep the same address, set spi_read=1 and pulse spi_flag once.
REQ-028 In WAIT_RD, on spi_over SHALL go to NEXT if spi_rdata==tbl_data, otherwise count a retry.
REQ-029 WAIT_WR and WAIT_RD SHALL each count cycles; reaching TIMEOUT_CYC without spi_over SHALL count a retry.
REQ-030 A retry with retry count < MAX_RETRY SHALL increment the count and return to ISSUE_WR for the same entry.
REQ-031 A retry with retry count == MAX_RETRY SHALL enter ERROR, set err=1 and latch err_idx=tbl_idx.
REQ-032 NEXT SHALL clear the retry count; if tbl_idx==N_ENTRIES-1 it SHALL enter DONE, otherwise increment tbl_idx and enter ISSUE_WR.
REQ-033 DONE SHALL set done=1 and busy=0.
REQ-034 ERROR SHALL set busy=0 and done=0.
REQ-035 DONE and ERROR SHALL hold until start.
REQ-036 start in DONE, ERROR or IDLE SHALL clear done, err and err_idx and enter PWR_WAIT.
REQ-037 start while busy=1 SHALL be ignored.
REQ-038 spi_over outside WAIT_WR and WAIT_RD SHALL be ignored.
REQ-039 spi_over in the same cycle as the timeout SHALL count as completion, not timeout.
REQ-040 Request-to-next-request latency with tbl_chk=0 SHALL be 2 cycles after spi_over: NEXT, then ISSUE_WR.
REQ-041 Counter widths SHALL be sized with $clog2 of their parameters; no counter may wrap silently.

Reset
REQ-042 On rst_n=0, regardless of state, SHALL asynchronously force the following: state=IDLE, counters=0, tbl_idx=0, spi_flag=0, spi_read=0, spi_addr=0, spi_data=0, busy=0, done=0, err=0, err_idx=0 and powerdown=1.
REQ-043 On rst_n deassertion, SHALL go IDLE to PWR_WAIT on the next clock.
REQ-044 Reset during an outstanding transaction SHALL abandon it; a later spi_over SHALL be ignored.

Verification
REQ-045 N_ENTRIES=3, tbl_chk=0, SPI model responds 10 cycles after each flag -> exactly 3 write flags, addresses in table order, done=1 after the third spi_over plus 1 cycle.
REQ-046 Entry 0 = {0x14,0x20,chk=1}, readback 0x20 -> write flag then read flag at address 0x14, advance to entry 1, err=0.
REQ-047 Readback always 0x00, expected 0x20, MAX_RETRY=3 -> 4 write and 4 read attempts, then err=1, err_idx=0, busy=0.
REQ-048 SPI model never asserts spi_over, TIMEOUT_CYC=16 -> retry every 16 cycles; after 4 attempts err=1.
REQ-049 rst_n pulsed low mid-WAIT_WR, stale spi_over 3 cycles after release -> powerdown=1 during reset, stale pulse ignored, sequence restarts at tbl_idx=0 after PWRUP_CYC.
REQ-050 start pulsed while busy, then again in DONE -> first start ignored; second clears done and reruns the full sequence.

Source files
------------

// File: rtl/ad9231_cfg_seq.sv
// AD9231 power-up configuration sequencer: walks an external register table,
// issuing SPI writes (optionally verified by readback) with per-entry retry.
module ad9231_cfg_seq #(
  parameter int N_ENTRIES   = 8,
  parameter int PWRUP_CYC   = 2000,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk_200m,
  input  logic        rst_n,
  input  logic        start,
  output logic [5:0]  tbl_idx,
  input  logic [12:0] tbl_addr,
  input  logic [7:0]  tbl_data,
  input  logic        tbl_chk,
  output logic [12:0] spi_addr,
  output logic [7:0]  spi_data,
  output logic        spi_read,
  output logic        spi_flag,
  input  logic        spi_over,
  input  logic [7:0]  spi_rdata,
  output logic        powerdown,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  err_idx
);

  localparam int PWR_W    = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;
  localparam int TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int PWR_LAST = (PWRUP_CYC > 0) ? PWRUP_CYC - 1 : 0;
  localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int IDX_LAST = N_ENTRIES - 1;

  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, NEXT, DONE, ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [5:0]        tbl_idx_q, tbl_idx_d;
  logic [12:0]       spi_addr_q, spi_addr_d;
  logic [7:0]        spi_data_q, spi_data_d;
  logic              spi_read_q, spi_read_d;
  logic              spi_flag_q, spi_flag_d;
  logic [5:0]        err_idx_q, err_idx_d;

  logic pwr_last, tmo_last, rty_last, idx_last, in_wait, retry_evt, restart;

  assign pwr_last = (pwr_cnt_q == PWR_W'(PWR_LAST));
  assign tmo_last = (tmo_cnt_q == TMO_W'(TMO_LAST));
  assign rty_last = (retry_q == RTY_W'(MAX_RETRY));
  assign idx_last = (tbl_idx_q == 6'(IDX_LAST));
  assign in_wait  = (state_q == WAIT_WR) || (state_q == WAIT_RD);
  assign restart  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

  // A completion pulse wins over a simultaneous timeout.
  always_comb begin
    retry_evt = 1'b0;
    if (state_q == WAIT_WR)
      retry_evt = !spi_over && tmo_last;
    else if (state_q == WAIT_RD)
      retry_evt = spi_over ? (spi_rdata != tbl_data) : tmo_last;
  end

  always_ff @(posedge clk_200m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pwr_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      retry_q    <= '0;
      tbl_idx_q  <= '0;
      spi_addr_q <= '0;
      spi_data_q <= '0;
      spi_read_q <= 1'b0;
      spi_flag_q <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      retry_q    <= retry_d;
      tbl_idx_q  <= tbl_idx_d;
      spi_addr_q <= spi_addr_d;
      spi_data_q <= spi_data_d;
      spi_read_q <= spi_read_d;
      spi_flag_q <= spi_flag_d;
      err_idx_q  <= err_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     state_d = PWR_WAIT;
      PWR_WAIT: if (pwr_last) state_d = ISSUE_WR;
      ISSUE_WR: state_d = WAIT_WR;
      WAIT_WR: begin
        if (spi_over)       state_d = tbl_chk ? ISSUE_RD : NEXT;
        else if (retry_evt) state_d = rty_last ? ERROR : ISSUE_WR;
      end
      ISSUE_RD: state_d = WAIT_RD;
      WAIT_RD: begin
        if (retry_evt)      state_d = rty_last ? ERROR : ISSUE_WR;
        else if (spi_over)  state_d = NEXT;
      end
      NEXT:     state_d = idx_last ? DONE : ISSUE_WR;
      DONE:     if (start) state_d = PWR_WAIT;
      ERROR:    if (start) state_d = PWR_WAIT;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    pwr_cnt_d  = ((state_q == PWR_WAIT) && !pwr_last) ? pwr_cnt_q + 1'b1 : '0;
    tmo_cnt_d  = (in_wait && !spi_over && !tmo_last) ? tmo_cnt_q + 1'b1 : '0;
    retry_d    = retry_q;
    tbl_idx_d  = tbl_idx_q;
    spi_addr_d = spi_addr_q;
    spi_data_d = spi_data_q;
    spi_read_d = spi_read_q;
    spi_flag_d = (state_q == ISSUE_WR) || (state_q == ISSUE_RD);
    err_idx_d  = err_idx_q;

    if (state_q == PWR_WAIT) begin
      retry_d   = '0;
      tbl_idx_d = '0;
    end
    if (state_q == NEXT) begin
      retry_d = '0;
      if (!idx_last) tbl_idx_d = tbl_idx_q + 6'd1;
    end
    if (retry_evt) begin
      if (rty_last) err_idx_d = tbl_idx_q;
      else          retry_d   = retry_q + 1'b1;
    end
    // Address/data are captured once per write and held until completion.
    if (state_q == ISSUE_WR) begin
      spi_addr_d = tbl_addr;
      spi_data_d = tbl_data;
      spi_read_d = 1'b0;
    end
    if (state_q == ISSUE_RD) spi_read_d = 1'b1;
    if (restart) err_idx_d = '0;
  end

  always_comb begin
    powerdown = (state_q == IDLE);
    busy      = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    done      = (state_q == DONE);
    err       = (state_q == ERROR);
  end

  assign tbl_idx  = tbl_idx_q;
  assign spi_addr = spi_addr_q;
  assign spi_data = spi_data_q;
  assign spi_read = spi_read_q;
  assign spi_flag = spi_flag_q;
  assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_ad9231_cfg_seq.sv
// Directed bench for ad9231_cfg_seq with a small SPI slave model that answers
// each request 10 cycles later and reads back the last written byte.
`timescale 1ns/1ps
module tb_ad9231_cfg_seq;

  localparam int NE  = 3;
  localparam int PWR = 20;
  localparam int TMO = 16;
  localparam int MR  = 3;

  logic        clk_200m = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  tbl_idx;
  logic [12:0] tbl_addr;
  logic [7:0]  tbl_data;
  logic        tbl_chk;
  logic [12:0] spi_addr;
  logic [7:0]  spi_data;
  logic        spi_read, spi_flag, spi_over;
  logic [7:0]  spi_rdata = 8'h00;
  logic        powerdown, busy, done, err;
  logic [5:0]  err_idx;

  logic [12:0] t_addr [NE];
  logic [7:0]  t_data [NE];
  logic        t_chk  [NE];
  logic        resp_en = 1'b1, rd_bad = 1'b0, over_force = 1'b0, model_over = 1'b0;
  int          pend = 0;
  logic [7:0]  last_wr = 8'h00;
  logic [12:0] log_addr[$];
  logic        log_rd[$];
  int          checks = 0, errors = 0;

  ad9231_cfg_seq #(.N_ENTRIES(NE), .PWRUP_CYC(PWR), .TIMEOUT_CYC(TMO), .MAX_RETRY(MR)) dut (
    .clk_200m(clk_200m), .rst_n(rst_n), .start(start), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_chk(tbl_chk),
    .spi_addr(spi_addr), .spi_data(spi_data), .spi_read(spi_read), .spi_flag(spi_flag),
    .spi_over(spi_over), .spi_rdata(spi_rdata), .powerdown(powerdown), .busy(busy),
    .done(done), .err(err), .err_idx(err_idx)
  );

  always #2.5 clk_200m = ~clk_200m;

  assign tbl_addr = (tbl_idx < NE) ? t_addr[tbl_idx[1:0]] : 13'h0;
  assign tbl_data = (tbl_idx < NE) ? t_data[tbl_idx[1:0]] : 8'h0;
  assign tbl_chk  = (tbl_idx < NE) ? t_chk[tbl_idx[1:0]]  : 1'b0;
  assign spi_over = model_over | over_force;

  // SPI slave: logs every request and answers 10 cycles after it.
  always @(negedge clk_200m) begin
    model_over <= 1'b0;
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        model_over <= 1'b1;
        spi_rdata  <= rd_bad ? 8'h00 : last_wr;
      end
    end
    if (spi_flag) begin
      log_addr.push_back(spi_addr);
      log_rd.push_back(spi_read);
      if (resp_en) pend <= 10;
      if (!spi_read) last_wr <= spi_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_200m);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk_200m);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    int c;
    c = 0;
    while (!(done || err) && c < bound) begin
      tick();
      c++;
    end
    chk("end_reached", 32'(done || err), 32'd1);
  endtask

  function automatic int count_rd(input int from, input logic rd);
    int n;
    n = 0;
    for (int i = from; i < log_rd.size(); i++)
      if (log_rd[i] == rd) n++;
    return n;
  endfunction

  initial begin
    int c, base, n_over, ocyc, nflag, pf;
    bit seen;
    t_addr[0] = 13'h008; t_data[0] = 8'h11; t_chk[0] = 1'b0;
    t_addr[1] = 13'h014; t_data[1] = 8'h22; t_chk[1] = 1'b0;
    t_addr[2] = 13'h0FF; t_data[2] = 8'h33; t_chk[2] = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_powerdown", 32'(powerdown), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_flag", 32'(spi_flag), 32'd0);
    chk("rst_idx", 32'(tbl_idx), 32'd0);
    chk("rst_err_idx", 32'(err_idx), 32'd0);
    chk("rst_addr", 32'(spi_addr), 32'd0);
    @(negedge clk_200m);
    rst_n = 1'b1;
    tick();
    chk("pwr_wait_powerdown", 32'(powerdown), 32'd0);
    chk("pwr_wait_busy", 32'(busy), 32'd1);

    // Three plain writes in table order
    base = log_addr.size();
    c = 1;
    while (!spi_flag && c < 100) begin tick(); c++; end
    chk("pwrup_latency", 32'(c), 32'(PWR + 2));
    chk("first_addr", 32'(spi_addr), 32'h008);
    chk("first_data", 32'(spi_data), 32'h11);
    chk("first_read", 32'(spi_read), 32'd0);
    n_over = 0; ocyc = 0; c = 0; seen = 0;
    while (!done && c < 500) begin
      tick(); c++;
      if (spi_over) begin
        n_over++; ocyc = c;
        if (n_over == 3) chk("done_in_next", 32'(done), 32'd0);
      end
      if (spi_flag && n_over == 1 && !seen) begin
        seen = 1;
        chk("req_to_req_latency", 32'(c - ocyc), 32'd2);
      end
    end
    chk("done_latency", 32'(c - ocyc), 32'd1);
    chk("a_writes", 32'(log_addr.size() - base), 32'd3);
    chk("a_reads", 32'(count_rd(base, 1'b1)), 32'd0);
    for (int i = 0; i < 3; i++)
      if (base + i < log_addr.size()) chk("a_addr_order", 32'(log_addr[base + i]), 32'(t_addr[i]));
    chk("a_err", 32'(err), 32'd0);
    chk("a_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("done_held", 32'(done), 32'd1);

    // Verified write on entry 0, restart from DONE
    t_addr[0] = 13'h014; t_data[0] = 8'h20; t_chk[0] = 1'b1;
    t_addr[1] = 13'h015;
    base = log_addr.size();
    pulse_start();
    chk("b_done_cleared", 32'(done), 32'd0);
    chk("b_busy", 32'(busy), 32'd1);
    wait_end(1000);
    chk("b_err", 32'(err), 32'd0);
    chk("b_done", 32'(done), 32'd1);
    chk("b_requests", 32'(log_addr.size() - base), 32'd4);
    if (log_addr.size() >= base + 3) begin
      chk("b_wr_addr", 32'(log_addr[base]), 32'h014);
      chk("b_wr_kind", 32'(log_rd[base]), 32'd0);
      chk("b_rd_addr", 32'(log_addr[base + 1]), 32'h014);
      chk("b_rd_kind", 32'(log_rd[base + 1]), 32'd1);
      chk("b_next_addr", 32'(log_addr[base + 2]), 32'h015);
    end

    // Entry 1 never answered: timeouts until error
    t_chk[0] = 1'b0;
    base = log_addr.size();
    pulse_start();
    c = 0;
    while (log_addr.size() < base + 1 && c < 200) begin tick(); c++; end
    resp_en = 1'b0;
    c = 0; nflag = 0; pf = 0;
    while (!err && !done && c < 1000) begin
      tick(); c++;
      if (spi_flag) begin
        if (nflag > 0) chk("timeout_interval", 32'(c - pf), 32'(TMO + 1));
        nflag++; pf = c;
      end
    end
    resp_en = 1'b1;
    chk("d_attempts", 32'(nflag), 32'(MR + 1));
    chk("d_err", 32'(err), 32'd1);
    chk("d_err_idx", 32'(err_idx), 32'd1);
    chk("d_busy", 32'(busy), 32'd0);
    chk("d_done", 32'(done), 32'd0);
    chk("d_writes", 32'(log_addr.size() - base), 32'd5);

    // Readback always wrong on entry 0, restart from ERROR
    t_chk[0] = 1'b1; rd_bad = 1'b1;
    base = log_addr.size();
    pulse_start();
    chk("c_err_cleared", 32'(err), 32'd0);
    chk("c_err_idx_cleared", 32'(err_idx), 32'd0);
    chk("c_busy", 32'(busy), 32'd1);
    wait_end(2000);
    chk("c_err", 32'(err), 32'd1);
    chk("c_err_idx", 32'(err_idx), 32'd0);
    chk("c_busy_end", 32'(busy), 32'd0);
    chk("c_writes", 32'(count_rd(base, 1'b0)), 32'(MR + 1));
    chk("c_reads", 32'(count_rd(base, 1'b1)), 32'(MR + 1));

    // Reset mid-transaction, stale completion, start while busy
    rd_bad = 1'b0;
    for (int i = 0; i < NE; i++) t_chk[i] = 1'b0;
    base = log_addr.size();
    pulse_start();
    c = 0;
    while (!spi_flag && c < 100) begin tick(); c++; end
    repeat (3) tick();
    @(negedge clk_200m);
    rst_n = 1'b0;
    #1;
    chk("e_async_powerdown", 32'(powerdown), 32'd1);
    chk("e_async_busy", 32'(busy), 32'd0);
    chk("e_async_addr", 32'(spi_addr), 32'd0);
    repeat (2) tick();
    chk("e_rst_powerdown", 32'(powerdown), 32'd1);
    @(negedge clk_200m);
    rst_n = 1'b1;
    base = log_addr.size();
    c = 0;
    repeat (3) begin tick(); c++; end
    @(negedge clk_200m);
    over_force = 1'b1;
    tick(); c++;
    chk("e_stale_busy", 32'(busy), 32'd1);
    @(negedge clk_200m);
    over_force = 1'b0;
    while (!spi_flag && c < 100) begin tick(); c++; end
    chk("e_restart_latency", 32'(c), 32'(PWR + 2));
    chk("e_restart_idx", 32'(tbl_idx), 32'd0);
    chk("e_restart_addr", 32'(spi_addr), 32'(t_addr[0]));
    pulse_start();
    chk("e_busy_start_busy", 32'(busy), 32'd1);
    wait_end(1000);
    chk("e_done", 32'(done), 32'd1);
    chk("e_writes", 32'(log_addr.size() - base), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
